// File: rtl/semaforo_pkg.sv
// Shared definitions for the timed two-street traffic light controller:
// state codes, lamp encodings and the state-to-lamp decode.
package semaforo_pkg;

    typedef enum logic [2:0] {
        S_RB = 3'd0,
        S_AG = 3'd1,
        S_AY = 3'd2,
        S_RA = 3'd3,
        S_BG = 3'd4,
        S_BY = 3'd5,
        S_WK = 3'd6
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Returns {LA, LB, walk}; anything not a known state shows all-red.
    function automatic logic [6:0] lights(input state_t s);
        logic [6:0] v;
        case (s)
            S_RB:    v = {RED, RED, 1'b0};
            S_AG:    v = {GRN, RED, 1'b0};
            S_AY:    v = {YEL, RED, 1'b0};
            S_RA:    v = {RED, RED, 1'b0};
            S_BG:    v = {RED, GRN, 1'b0};
            S_BY:    v = {RED, YEL, 1'b0};
            S_WK:    v = {RED, RED, 1'b1};
            default: v = {RED, RED, 1'b0};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-enabled phase duration counter with synchronous clear and optional
// saturation at a programmable value.
module phase_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          tick,
    input  logic          sat,
    input  logic [TW-1:0] sat_val,
    output logic [TW-1:0] count
);

    logic [TW-1:0] count_reg;
    logic          at_limit;

    assign at_limit = sat && (count_reg == sat_val);
    assign count    = count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (tick && !at_limit) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/semaforo_temporizado.sv
// Demand-driven two-street traffic light controller (Moore FSM, registered
// lamp outputs). Define PED_CROSS_EN to enable the pedestrian WALK phase.
module semaforo_temporizado
    import semaforo_pkg::*;
#(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 15,
    parameter int YELLOW_T  = 3,
    parameter int CLEAR_T   = 1,
    parameter int WALK_T    = 6,
    parameter int TW        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       TA,
    input  logic       TB,
    input  logic       ped_btn,
    output logic [2:0] LA,
    output logic [2:0] LB,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [TW-1:0] MIN_M1  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_M1  = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_M1  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] CLR_M1  = TW'(CLEAR_T - 1);
    localparam logic [TW-1:0] WALK_M1 = TW'(WALK_T - 1);

    state_t        state_reg;
    state_t        state_next;
    state_t        wk_exit_state;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic          timer_sat;
    logic          walk_req;
    logic [6:0]    lamp_next;

    logic [2:0]    la_reg;
    logic [2:0]    lb_reg;
    logic          walk_reg;
    logic [2:0]    phase_reg;

    assign timer_clr = (state_next != state_reg);
    assign timer_sat = (state_reg == S_AG) || (state_reg == S_BG);

    phase_timer #(
        .TW(TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .tick    (tick),
        .sat     (timer_sat),
        .sat_val (MAX_M1),
        .count   (timer)
    );

`ifdef PED_CROSS_EN
    logic ped_pend_reg;
    logic dir_reg;
    logic enter_wk;

    assign walk_req      = ped_pend_reg;
    assign wk_exit_state = dir_reg ? S_BG : S_AG;
    assign enter_wk      = (state_next == S_WK) && (state_reg != S_WK);

    // dir_reg=1 means WALK was entered from RA, so street B gets green next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pend_reg <= 1'b0;
            dir_reg      <= 1'b0;
        end else begin
            if (ped_btn) begin
                ped_pend_reg <= 1'b1;
            end else if (enter_wk) begin
                ped_pend_reg <= 1'b0;
            end
            if (enter_wk) begin
                dir_reg <= (state_reg == S_RA);
            end
        end
    end
`else
    logic [1:0] unused_ped;

    assign walk_req      = 1'b0;
    assign wk_exit_state = S_RB;
    assign unused_ped    = {ped_btn, lamp_next[0]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_RB;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RB: begin
                if (tick && timer == CLR_M1) begin
                    state_next = walk_req ? S_WK : S_AG;
                end
            end
            S_AG: begin
                if (tick && TB && timer >= MIN_M1 && (!TA || timer == MAX_M1)) begin
                    state_next = S_AY;
                end
            end
            S_AY: begin
                if (tick && timer == YEL_M1) begin
                    state_next = S_RA;
                end
            end
            S_RA: begin
                if (tick && timer == CLR_M1) begin
                    state_next = walk_req ? S_WK : S_BG;
                end
            end
            S_BG: begin
                if (tick && TA && timer >= MIN_M1 && (!TB || timer == MAX_M1)) begin
                    state_next = S_BY;
                end
            end
            S_BY: begin
                if (tick && timer == YEL_M1) begin
                    state_next = S_RB;
                end
            end
            S_WK: begin
                if (tick && timer == WALK_M1) begin
                    state_next = wk_exit_state;
                end
            end
            // Unused encoding recovers without waiting for a tick.
            default: state_next = S_RB;
        endcase
    end

    assign lamp_next = lights(state_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            la_reg    <= RED;
            lb_reg    <= RED;
            walk_reg  <= 1'b0;
            phase_reg <= 3'd0;
        end else begin
            la_reg    <= lamp_next[6:4];
            lb_reg    <= lamp_next[3:1];
`ifdef PED_CROSS_EN
            walk_reg  <= lamp_next[0];
`else
            walk_reg  <= 1'b0;
`endif
            phase_reg <= state_reg;
        end
    end

    assign LA    = la_reg;
    assign LB    = lb_reg;
    assign walk  = walk_reg;
    assign phase = phase_reg;

endmodule
